// File: rtl/req_gnt_responder.sv
// rtl/req_gnt_responder.sv - round-robin REQ/GNT responder issuing one-cycle one-hot grants
// Optional per-requester starvation monitor built when REQ_GNT_STARVE_MON_EN is defined.
module req_gnt_responder #(
    parameter int NUM_REQ  = 2,
    parameter int MIN_GAP  = 0,
    parameter int MAX_WAIT = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               ready,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [IDW-1:0]     gnt_id,
    output logic [NUM_REQ-1:0] starve
);

    localparam int SW = IDW + 2;
    localparam logic [3:0] GAP_LOAD = (MIN_GAP > 0) ? 4'(MIN_GAP - 1) : 4'd0;

    if (NUM_REQ < 2 || NUM_REQ > 16 || MIN_GAP < 0 || MIN_GAP > 15 || MAX_WAIT < 1) begin : g_bad_cfg
        $error("req_gnt_responder: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_d;
    logic [IDW-1:0]     gnt_id_d;
    logic [IDW-1:0]     last_q, last_d;
    logic [3:0]         gap_q, gap_d;

    logic [SW-1:0]        rr_start;
    logic [NUM_REQ-1:0]   req_rot;
    logic [SW-1:0]        win_off;
    logic [SW-1:0]        win_sum;
    logic                 win_found;
    logic [IDW-1:0]       win_id;

    // Rotate requests so bit 0 is the requester just after the last winner.
    assign rr_start = SW'(last_q) + SW'(1);
    assign req_rot  = NUM_REQ'({req, req} >> rr_start);

    always_comb begin
        win_found = 1'b0;
        win_off   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_found = 1'b1;
                win_off   = SW'(i);
            end
        end
        win_sum = rr_start + win_off;
        if (win_sum >= SW'(NUM_REQ)) begin
            win_sum = win_sum - SW'(NUM_REQ);
        end
        win_id = IDW'(win_sum);
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = '0;
        gnt_id_d = gnt_id;
        last_d   = last_q;
        gap_d    = gap_q;
        case (state_q)
            S_IDLE: begin
                if (ready && win_found) begin
                    gnt_d    = NUM_REQ'(1) << win_id;
                    gnt_id_d = win_id;
                    last_d   = win_id;
                    state_d  = S_GRANT;
                end
            end
            S_GRANT: begin
                if (MIN_GAP > 0) begin
                    state_d = S_GAP;
                    gap_d   = GAP_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            gnt     <= '0;
            gnt_id  <= '0;
            last_q  <= IDW'(NUM_REQ - 1);
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt     <= gnt_d;
            gnt_id  <= gnt_id_d;
            last_q  <= last_d;
            gap_q   <= gap_d;
        end
    end

    assign gnt_valid = |gnt;

`ifdef REQ_GNT_STARVE_MON_EN
    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] wait_cnt [NUM_REQ];

    // A wait counter restarts whenever its requester is idle or currently granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req[i] || gnt[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] != CW'(MAX_WAIT)) begin
                    wait_cnt[i] <= wait_cnt[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        starve = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            starve[i] = (wait_cnt[i] == CW'(MAX_WAIT));
        end
    end
`else
    assign starve = '0;
`endif

endmodule

// File: tb/tb_req_gnt_responder.sv
// tb/tb_req_gnt_responder.sv - directed and randomized checks of req_gnt_responder against a behavioural model
`timescale 1ns/1ps
module tb_req_gnt_responder;

    localparam int NI = 3;
`ifdef REQ_GNT_STARVE_MON_EN
    localparam bit MON = 1'b1;
`else
    localparam bit MON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0] req_a, gnt_a, st_a;
    logic [0:0] id_a;
    logic       rdy_a, val_a;
    logic [3:0] req_b, gnt_b, st_b;
    logic [1:0] id_b;
    logic       rdy_b, val_b;
    logic [2:0] req_c, gnt_c, st_c;
    logic [1:0] id_c;
    logic       rdy_c, val_c;

    req_gnt_responder #(.NUM_REQ(2), .MIN_GAP(0), .MAX_WAIT(4)) dut_a (
        .clk(clk), .reset(reset), .req(req_a), .ready(rdy_a),
        .gnt(gnt_a), .gnt_valid(val_a), .gnt_id(id_a), .starve(st_a));
    req_gnt_responder #(.NUM_REQ(4), .MIN_GAP(0), .MAX_WAIT(8)) dut_b (
        .clk(clk), .reset(reset), .req(req_b), .ready(rdy_b),
        .gnt(gnt_b), .gnt_valid(val_b), .gnt_id(id_b), .starve(st_b));
    req_gnt_responder #(.NUM_REQ(3), .MIN_GAP(2), .MAX_WAIT(12)) dut_c (
        .clk(clk), .reset(reset), .req(req_c), .ready(rdy_c),
        .gnt(gnt_c), .gnt_valid(val_c), .gnt_id(id_c), .starve(st_c));

    logic [15:0] o_gnt [NI];
    logic        o_val [NI];
    logic [3:0]  o_id  [NI];
    logic [15:0] o_st  [NI];
    always_comb begin
        o_gnt[0] = 16'(gnt_a); o_val[0] = val_a; o_id[0] = 4'(id_a); o_st[0] = 16'(st_a);
        o_gnt[1] = 16'(gnt_b); o_val[1] = val_b; o_id[1] = 4'(id_b); o_st[1] = 16'(st_b);
        o_gnt[2] = 16'(gnt_c); o_val[2] = val_c; o_id[2] = 4'(id_c); o_st[2] = 16'(st_c);
    end

    logic [15:0] rq    [NI];
    logic        rdy   [NI];
    logic [15:0] e_gnt [NI];
    logic [15:0] e_st  [NI];
    int          last_m   [NI];
    int          next_arb [NI];
    int          wait_m   [NI][16];
    int          edge_no;
    int          checks = 0;
    int          errors = 0;

    function automatic int n_of(int k);
        return (k == 0) ? 2 : ((k == 1) ? 4 : 3);
    endfunction
    function automatic int gap_of(int k);
        return (k == 2) ? 2 : 0;
    endfunction
    function automatic int maxw_of(int k);
        return (k == 0) ? 4 : ((k == 1) ? 8 : 12);
    endfunction
    function automatic int idx_of(logic [15:0] g);
        for (int i = 0; i < 16; i++) if (g[i]) return i;
        return 0;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NI; k++) begin
            last_m[k] = n_of(k) - 1;
            next_arb[k] = 0;
            e_gnt[k] = '0;
            e_st[k] = '0;
            for (int i = 0; i < 16; i++) wait_m[k][i] = 0;
        end
        edge_no = 0;
    endfunction

    // One rising edge: arbitration allowed only once 2+MIN_GAP edges have passed since the last grant.
    function automatic void model_edge();
        for (int k = 0; k < NI; k++) begin
            int n = n_of(k);
            logic [15:0] r = rq[k] & ((16'd1 << n) - 16'd1);
            logic [15:0] g = '0;
            for (int i = 0; i < n; i++) begin
                if (!r[i] || e_gnt[k][i]) wait_m[k][i] = 0;
                else if (wait_m[k][i] < maxw_of(k)) wait_m[k][i]++;
            end
            if (edge_no >= next_arb[k] && rdy[k] && r != 16'd0) begin
                for (int s = 1; s <= n; s++) begin
                    int c = (last_m[k] + s) % n;
                    if (g == 16'd0 && r[c]) begin
                        g[c] = 1'b1;
                        last_m[k] = c;
                    end
                end
                next_arb[k] = edge_no + 2 + gap_of(k);
            end
            e_gnt[k] = g;
            e_st[k] = '0;
            for (int i = 0; i < n; i++) e_st[k][i] = MON && (wait_m[k][i] == maxw_of(k));
        end
        edge_no++;
    endfunction

    function automatic void drive_ports();
        req_a = rq[0][1:0]; rdy_a = rdy[0];
        req_b = rq[1][3:0]; rdy_b = rdy[1];
        req_c = rq[2][2:0]; rdy_c = rdy[2];
    endfunction

    // Requesters drop after seeing their grant and otherwise hold; rnd adds random raise/abandon.
    function automatic void requesters(int k, bit rnd, logic [15:0] mask);
        for (int i = 0; i < n_of(k); i++) begin
            if (mask[i]) begin
                if (e_gnt[k][i]) rq[k][i] = 1'b0;
                else if (rq[k][i]) begin
                    if (rnd && $urandom_range(0, 19) == 0) rq[k][i] = 1'b0;
                end else if (!rnd || $urandom_range(0, 2) == 0) rq[k][i] = 1'b1;
            end
        end
    endfunction

    task automatic tick();
        drive_ports();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int k = 0; k < NI; k++) begin
            rq[k] = '0;
            rdy[k] = 1'b0;
        end
        drive_ports();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < NI; k++) begin
            checks++; if (o_gnt[k] !== 16'd0) begin errors++; $display("FAIL reset_gnt k=%0d got %h want 0", k, o_gnt[k]); end
            checks++; if (o_val[k] !== 1'b0) begin errors++; $display("FAIL reset_valid k=%0d got %b want 0", k, o_val[k]); end
            checks++; if (o_id[k] !== 4'd0) begin errors++; $display("FAIL reset_id k=%0d got %0d want 0", k, o_id[k]); end
            checks++; if (o_st[k] !== 16'd0) begin errors++; $display("FAIL reset_starve k=%0d got %h want 0", k, o_st[k]); end
        end
    endtask

    task automatic test_single_request();
        do_reset();
        rdy[0] = 1'b1;
        for (int t = 0; t < 6; t++) begin
            logic [1:0] want;
            if (t == 2) rq[0] = 16'h1;
            tick();
            want = (t == 2) ? 2'b01 : 2'b00;
            checks++; if (gnt_a !== want) begin errors++; $display("FAIL single_gnt t=%0d got %b want %b", t, gnt_a, want); end
            checks++; if (val_a !== (t == 2)) begin errors++; $display("FAIL single_valid t=%0d got %b want %b", t, val_a, t == 2); end
            if (t == 2) begin
                checks++; if (id_a !== 1'b0) begin errors++; $display("FAIL single_id got %0d want 0", id_a); end
                rq[0] = '0;
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        rdy[1] = 1'b1;
        rq[1] = 16'hF;
        for (int t = 0; t < 12; t++) begin
            logic [3:0] want;
            tick();
            want = (t % 2 == 0) ? (4'b1 << ((t / 2) % 4)) : 4'b0;
            checks++; if (gnt_b !== want) begin errors++; $display("FAIL rr_gnt t=%0d got %b want %b", t, gnt_b, want); end
            checks++; if ($countones(gnt_b) > 1) begin errors++; $display("FAIL rr_onehot t=%0d got %b want at most one bit", t, gnt_b); end
            if (want != 4'b0) begin
                checks++; if (id_b !== 2'((t / 2) % 4)) begin errors++; $display("FAIL rr_id t=%0d got %0d want %0d", t, id_b, (t / 2) % 4); end
            end
            requesters(1, 1'b0, 16'hF);
        end
    endtask

    task automatic test_gap();
        do_reset();
        rdy[2] = 1'b1;
        rq[2] = 16'h3;
        for (int t = 0; t < 12; t++) begin
            logic [2:0] want;
            tick();
            want = (t % 4 == 0) ? (3'b1 << ((t / 4) % 2)) : 3'b0;
            checks++; if (gnt_c !== want) begin errors++; $display("FAIL gap_gnt t=%0d got %b want %b", t, gnt_c, want); end
            checks++; if (val_c !== (want != 3'b0)) begin errors++; $display("FAIL gap_valid t=%0d got %b want %b", t, val_c, want != 3'b0); end
            requesters(2, 1'b0, 16'h3);
        end
    endtask

    task automatic test_stall_starve();
        do_reset();
        rq[0] = 16'h2;
        rdy[0] = 1'b0;
        for (int t = 0; t < 8; t++) begin
            logic [1:0] want_st;
            tick();
            want_st = {MON && (t >= 3), 1'b0};
            checks++; if (gnt_a !== 2'b00) begin errors++; $display("FAIL stall_gnt t=%0d got %b want 00", t, gnt_a); end
            checks++; if (st_a !== want_st) begin errors++; $display("FAIL stall_starve t=%0d got %b want %b", t, st_a, want_st); end
        end
        rdy[0] = 1'b1;
        tick();
        checks++; if (gnt_a !== 2'b10) begin errors++; $display("FAIL stall_release_gnt got %b want 10", gnt_a); end
        checks++; if (id_a !== 1'b1) begin errors++; $display("FAIL stall_release_id got %0d want 1", id_a); end
        checks++; if (st_a !== {MON, 1'b0}) begin errors++; $display("FAIL stall_release_starve got %b want %b", st_a, {MON, 1'b0}); end
        rq[0] = '0;
        tick();
        checks++; if (gnt_a !== 2'b00) begin errors++; $display("FAIL stall_after_gnt got %b want 00", gnt_a); end
        checks++; if (st_a !== 2'b00) begin errors++; $display("FAIL stall_after_starve got %b want 00", st_a); end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        rq[0] = 16'h2;
        rdy[0] = 1'b1;
        tick();
        checks++; if (gnt_a !== 2'b10) begin errors++; $display("FAIL midrst_pre_gnt got %b want 10", gnt_a); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (gnt_a !== 2'b00) begin errors++; $display("FAIL midrst_async_gnt got %b want 00", gnt_a); end
        checks++; if (val_a !== 1'b0) begin errors++; $display("FAIL midrst_async_valid got %b want 0", val_a); end
        checks++; if (st_a !== 2'b00) begin errors++; $display("FAIL midrst_async_starve got %b want 00", st_a); end
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        rq[0] = 16'h3;
        tick();
        checks++; if (gnt_a !== 2'b01) begin errors++; $display("FAIL midrst_first_gnt got %b want 01", gnt_a); end
        rq[0] = '0;
        tick();
        checks++; if (gnt_a !== 2'b00) begin errors++; $display("FAIL midrst_no_replay got %b want 00", gnt_a); end
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 600; t++) begin
            for (int k = 0; k < NI; k++) begin
                rdy[k] = ($urandom_range(0, 3) != 0);
                requesters(k, 1'b1, 16'hFFFF);
            end
            tick();
            for (int k = 0; k < NI; k++) begin
                checks++; if (o_gnt[k] !== e_gnt[k]) begin errors++; $display("FAIL rand_gnt t=%0d k=%0d got %h want %h", t, k, o_gnt[k], e_gnt[k]); end
                checks++; if (o_val[k] !== (e_gnt[k] != 16'd0)) begin errors++; $display("FAIL rand_valid t=%0d k=%0d got %b want %b", t, k, o_val[k], e_gnt[k] != 16'd0); end
                checks++; if (o_st[k] !== e_st[k]) begin errors++; $display("FAIL rand_starve t=%0d k=%0d got %h want %h", t, k, o_st[k], e_st[k]); end
                if (e_gnt[k] != 16'd0) begin
                    checks++; if (o_id[k] !== 4'(idx_of(e_gnt[k]))) begin errors++; $display("FAIL rand_id t=%0d k=%0d got %0d want %0d", t, k, o_id[k], idx_of(e_gnt[k])); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_request();
        test_round_robin();
        test_gap();
        test_stall_starve();
        test_reset_mid_grant();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/req_gnt_responder.md
# req_gnt_responder

Grant-side responder for the REQ/GNT handshake. It accepts level requests from `NUM_REQ` initiators and issues one-cycle, one-hot grant pulses in round-robin order. Grant latency is bounded whenever `ready` is held, so the bench's bounded-latency REQ→GNT property holds. It sits between the requesting agents and the shared downstream resource, which gates grants with `ready`.

## Interface
- `NUM_REQ`, default 2: number of requesters, range 2..16.
- `MIN_GAP`, default 0: idle cycles inserted after every grant, range 0..15.
- `MAX_WAIT`, default 4: starvation threshold in cycles; must be ≥ `NUM_REQ*(2+MIN_GAP)` for a starvation-free configuration.
- `IDW` (derived): `$clog2(NUM_REQ)`.

- `clk`  in  1  — clock; all state updates on the rising edge.
- `reset`  in  1  — asynchronous, active-high reset.
- `req`  in  NUM_REQ  — level request per initiator. Held high until the initiator samples its `gnt` bit high, then dropped the following cycle.
- `ready`  in  1  — downstream can accept a grant. Sampled only in IDLE.
- `gnt`  out  NUM_REQ  — registered, one-hot, single-cycle grant pulse.
- `gnt_valid`  out  1  — equals `|gnt`.
- `gnt_id`  out  IDW  — index of the granted requester; valid only while `gnt_valid` is high.
- `starve`  out  NUM_REQ  — per-requester wait-exceeded flag; present only with the macro, otherwise tied to 0.

## Operation
- FSM states: IDLE, GRANT, GAP.
- IDLE: if `ready` is high and `req != 0`, pick the first set `req` bit searching upward from `last+1`, wrapping modulo `NUM_REQ`. Register `gnt`/`gnt_id`, set `last` to the winner, and go to GRANT. Otherwise stay in IDLE.
- GRANT (1 cycle): `gnt` is high. Next state is GAP if `MIN_GAP>0`, else IDLE. `gnt` clears on exit.
- GAP: a counter loads `MIN_GAP-1` on entry and decrements; return to IDLE when it reaches 0. `req` and `ready` are ignored in GAP.
- No masking of the granted requester is needed. Its `req` is low by the next IDLE evaluation, because it drops after the edge that shows `gnt`.
- A requester that drops `req` before being granted is simply not selected. No error is raised.
- Arbitration uses `ready` and `req` sampled at the same edge. There are no combinational paths from inputs to outputs.
- Reset values: state=IDLE, `gnt`=0, `gnt_valid`=0, `gnt_id`=0, `last`=`NUM_REQ-1` (so `req[0]` wins first), gap counter=0, `starve`=0, wait counters=0.
- Reset asserted mid-grant or mid-gap: all outputs clear immediately, without waiting for a clock edge. No grant is replayed after reset is released.

## Timing
- Latency: `req` and `ready` high at edge n while in IDLE → `gnt` high from edge n to edge n+1.
- Grant period with continuous demand is `2+MIN_GAP` cycles.
- Worst-case latency from `req` rise to `gnt` is `NUM_REQ*(2+MIN_GAP)` cycles, provided `ready` is held high.
- `ready` low in IDLE stalls arbitration indefinitely. The round-robin pointer is unchanged during the stall.

## Configuration
- Macro `REQ_GNT_STARVE_MON_EN`.
- Defined: one saturating wait counter per requester, width `$clog2(MAX_WAIT+1)`.
  - Each edge: the counter clears if `req[i]` is low or `gnt[i]` is high; otherwise it increments, saturating at `MAX_WAIT`.
  - `starve[i]` = (counter == `MAX_WAIT`). It is a registered-state output and stays high until the requester is granted or drops `req`; it clears at the next edge.
- Undefined: no counters are built and `starve` is constant 0. Grant behaviour is identical in both builds.

## Test plan
- Single request: `NUM_REQ=2`, `req[0]` rises 2 cycles after reset release, `ready=1` → `gnt=2'b01`, `gnt_id=0`, `gnt_valid=1` exactly one cycle after the sampling edge; pulse width 1 cycle.
- Round-robin: `NUM_REQ=4`, all `req` held, each requester re-raises one cycle after dropping → grants to 0,1,2,3,0,1 every 2 cycles; never two `gnt` bits set at once.
- Gap: `MIN_GAP=2`, two requesters held → grants spaced 4 cycles apart; no `gnt` during GAP even with `ready=1`.
- Stall/starvation (macro on): `MAX_WAIT=4`, `req[1]` high, `ready=0` for 8 cycles → no grant; `starve[1]` high after 4 edges. Then `ready=1` → `gnt[1]` on the next cycle; `starve[1]` low one edge later.
- Reset mid-grant: assert `reset` while `gnt[1]=1` → `gnt`, `gnt_valid`, `starve` drop before the next edge. After release, with all `req` high, the first grant goes to `req[0]`.
- Macro off: repeat the stall scenario → `starve` stays 0; grant sequence is identical to the macro-on run.
